mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-port arbiter sharing the single cache request/response port (27-bit address, 32-bit data, rw, valid / data, ready) between the instruction-fetch unit and the load/store unit. It sits between the core and the cache/DRAM front end, on sys_clk. It latches one granted request, holds it on the cache port until the cache answers, and routes the response back to the owner. Exactly one transaction is outstanding at a time.

## Interface
- ADDR_W, 27, request address width
- DATA_W, 32, data width
- sys_clk  in  1  core/cache clock; all logic on rising edge
- rstn  in  1  reset, synchronous and active-low
- if_req_valid  in  1  fetch request; held until if_res_ready
- if_req_addr  in  ADDR_W  fetch address; fetch is always a read
- if_res_data  out  DATA_W  fetch read data; valid when if_res_ready=1
- if_res_ready  out  1  one-cycle completion pulse to fetch
- ls_req_valid  in  1  load/store request; held until ls_res_ready
- ls_req_addr  in  ADDR_W  load/store address
- ls_req_data  in  DATA_W  store data
- ls_req_rw  in  1  1=write, 0=read
- ls_res_data  out  DATA_W  load data; valid when ls_res_ready=1
- ls_res_ready  out  1  one-cycle completion pulse to load/store
- cpu_req_addr / cpu_req_data / cpu_req_rw / cpu_req_valid  out  ADDR_W/DATA_W/1/1  cache request
- cpu_res_data  in  DATA_W  cache response data
- cpu_res_ready  in  1  cache completion pulse

## Operation
- FSM states: IDLE, BUSY, GAP.
- IDLE: sample if_req_valid and ls_req_valid. If neither is set, stay in IDLE. Otherwise pick an owner, register addr/data/rw into the request register (fetch: rw=0, data=0), register the owner, and go to BUSY.
- BUSY: cpu_req_valid=1 with the registered request, held stable. On cpu_res_ready=1: register cpu_res_data into the owner's res_data, set the owner's res_ready for the next cycle only, and go to GAP.
- GAP: cpu_req_valid=0 and inputs ignored. Unconditionally go to IDLE. This guarantees the cache sees valid low for at least one cycle between transactions.
- Requester rule: in the cycle after the one where x_res_ready=1, the requester presents either a new request or valid=0. The arbiter never re-samples a stale request.
- Write responses: ls_res_ready pulses normally. ls_res_data carries cpu_res_data and is don't-care.
- The non-owner's res_ready stays 0. Its res_data holds its previous value.
- cpu_res_ready is ignored in IDLE and GAP. No error is raised.

## Timing
- Reset values: cpu_req_valid=0, cpu_req_rw=0, cpu_req_addr=0, cpu_req_data=0, if_res_ready=0, ls_res_ready=0, if_res_data=0, ls_res_data=0. State=IDLE. The round-robin pointer points to load/store.
- A request sampled in IDLE at cycle t gives cpu_req_valid=1 at t+1.
- cpu_res_ready at cycle r gives x_res_ready=1 at r+1 (GAP). IDLE is at r+2, and a new request can be sampled there.
- Minimum turnaround for back-to-back requests: cache latency + 3 cycles.
- If both requesters are valid in the same IDLE cycle, the arbitration rule decides (see Configuration).
- If rstn is low mid-BUSY, the outstanding transaction is abandoned and all outputs take their reset values at the next edge. The cache is reset by the same rstn.
- The registered request never changes while in BUSY, even if the requester's inputs change.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when both requesters are valid, the arbiter grants the one not granted last. A one-bit pointer updates on each grant.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, load/store over fetch. There is no pointer register.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_t (IDLE, BUSY, GAP)
  - arb_owner_t (OWN_IF, OWN_LS)
  - the ADDR_W and DATA_W default constants.
- Sub-module mem_arb_pick: combinational two-way picker. Inputs are both valids and the last owner. Output is the granted owner. The macro selects round-robin or fixed priority inside it.

## Test plan
- Fetch only: if addr=0x100, cache returns 0xDEADBEEF after 5 cycles → cpu_req_valid rises 1 cycle after the request, if_res_ready pulses once with 0xDEADBEEF, and cpu_req_valid is low for ≥1 cycle after.
- Store: ls addr=0x2000, data=0x12345678, rw=1 → cache sees exactly addr 0x2000, data 0x12345678, rw=1, stable through BUSY. ls_res_ready pulses once.
- Simultaneous requests, both held valid for 4 transactions:
  - round-robin: grant order LS, IF, LS, IF.
  - fixed priority: LS every time while LS stays valid.
- Request input changes during BUSY: change ls_req_addr from 0x40 to 0x80 mid-BUSY → cpu_req_addr stays 0x40.
- Reset mid-BUSY: assert rstn=0 for one cycle → all outputs take reset values and no res_ready pulse occurs. A new fetch after reset completes normally.
- Spurious cpu_res_ready in IDLE → no res_ready pulse and state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch / load-store memory request arbiter.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 27;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
  typedef enum logic       {OWN_IF, OWN_LS}  arb_owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational grant picker.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise load/store has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_vld_i,
  input  logic       ls_vld_i,
  input  arb_owner_t last_i,
  output arb_owner_t grant_o
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_o = OWN_IF;
    if (if_vld_i && ls_vld_i) grant_o = (last_i == OWN_LS) ? OWN_IF : OWN_LS;
    else if (ls_vld_i)        grant_o = OWN_LS;
  end
`else
  logic unused_last;
  assign unused_last = last_i;
  always_comb begin
    grant_o = ls_vld_i ? OWN_LS : OWN_IF;
  end
`endif
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one cache request/response port between fetch and load/store; one transaction
// outstanding at a time. Arbitration mode set by MEM_ARB_ROUND_ROBIN_EN.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic [DATA_W-1:0] if_res_data,
  output logic              if_res_ready,
  input  logic              ls_req_valid,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_data,
  input  logic              ls_req_rw,
  output logic [DATA_W-1:0] ls_res_data,
  output logic              ls_res_ready,
  output logic [ADDR_W-1:0] cpu_req_addr,
  output logic [DATA_W-1:0] cpu_req_data,
  output logic              cpu_req_rw,
  output logic              cpu_req_valid,
  input  logic [DATA_W-1:0] cpu_res_data,
  input  logic              cpu_res_ready
);
  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        grant, last;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              if_rdy_q, if_rdy_d, ls_rdy_q, ls_rdy_d;
  logic [DATA_W-1:0] if_rdat_q, if_rdat_d, ls_rdat_q, ls_rdat_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Pointer holds the last grant; reset to fetch so load/store wins the first tie.
  arb_owner_t last_q, last_d;
  assign last = last_q;
  always_ff @(posedge sys_clk) begin
    if (!rstn) last_q <= OWN_IF;
    else       last_q <= last_d;
  end
  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (if_req_valid || ls_req_valid)) last_d = grant;
  end
`else
  assign last = OWN_IF;
`endif

  mem_arb_pick u_pick (
    .if_vld_i (if_req_valid),
    .ls_vld_i (ls_req_valid),
    .last_i   (last),
    .grant_o  (grant)
  );

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      if_rdy_q  <= 1'b0;
      ls_rdy_q  <= 1'b0;
      if_rdat_q <= '0;
      ls_rdat_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      if_rdy_q  <= if_rdy_d;
      ls_rdy_q  <= ls_rdy_d;
      if_rdat_q <= if_rdat_d;
      ls_rdat_q <= ls_rdat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    if_rdy_d  = 1'b0;
    ls_rdy_d  = 1'b0;
    if_rdat_d = if_rdat_q;
    ls_rdat_d = ls_rdat_q;
    case (state_q)
      IDLE: begin
        if (if_req_valid || ls_req_valid) begin
          owner_d = grant;
          state_d = BUSY;
          if (grant == OWN_LS) begin
            addr_d = ls_req_addr;
            data_d = ls_req_data;
            rw_d   = ls_req_rw;
          end else begin
            addr_d = if_req_addr;
            data_d = '0;
            rw_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        if (cpu_res_ready) begin
          state_d = GAP;
          if (owner_q == OWN_LS) begin
            ls_rdy_d  = 1'b1;
            ls_rdat_d = cpu_res_data;
          end else begin
            if_rdy_d  = 1'b1;
            if_rdat_d = cpu_res_data;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_req_valid = (state_q == BUSY);
    cpu_req_addr  = addr_q;
    cpu_req_data  = data_q;
    cpu_req_rw    = rw_q;
    if_res_ready  = if_rdy_q;
    ls_res_ready  = ls_rdy_q;
    if_res_data   = if_rdat_q;
    ls_res_data   = ls_rdat_q;
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_req_arbiter;
  logic        sys_clk, rstn;
  logic        if_req_valid;
  logic [26:0] if_req_addr;
  logic [31:0] if_res_data;
  logic        if_res_ready;
  logic        ls_req_valid;
  logic [26:0] ls_req_addr;
  logic [31:0] ls_req_data;
  logic        ls_req_rw;
  logic [31:0] ls_res_data;
  logic        ls_res_ready;
  logic [26:0] cpu_req_addr;
  logic [31:0] cpu_req_data;
  logic        cpu_req_rw;
  logic        cpu_req_valid;
  logic [31:0] cpu_res_data;
  logic        cpu_res_ready;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl_if = 0, mdl_ls = 0;

  mem_req_arbiter dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_res_data(if_res_data), .if_res_ready(if_res_ready),
    .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr),
    .ls_req_data(ls_req_data), .ls_req_rw(ls_req_rw),
    .ls_res_data(ls_res_data), .ls_res_ready(ls_res_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_rw(cpu_req_rw), .cpu_req_valid(cpu_req_valid),
    .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_vld"},   32'(cpu_req_valid), 32'h0);
    chk({tag, "_rw"},    32'(cpu_req_rw),    32'h0);
    chk({tag, "_addr"},  32'(cpu_req_addr),  32'h0);
    chk({tag, "_data"},  cpu_req_data,       32'h0);
    chk({tag, "_ifrdy"}, 32'(if_res_ready),  32'h0);
    chk({tag, "_lsrdy"}, 32'(ls_res_ready),  32'h0);
    chk({tag, "_ifdat"}, if_res_data,        32'h0);
    chk({tag, "_lsdat"}, ls_res_data,        32'h0);
  endtask

  // Called in an IDLE cycle with the request already on the inputs.
  task automatic txn(input string tag, input logic [26:0] ea, input logic [31:0] ed,
                     input logic erw, input logic own_ls, input int lat,
                     input logic [31:0] rd, input logic chg, input logic [26:0] chg_addr);
    step;
    chk({tag, "_vld"},  32'(cpu_req_valid), 32'h1);
    chk({tag, "_addr"}, 32'(cpu_req_addr),  32'(ea));
    chk({tag, "_data"}, cpu_req_data,       ed);
    chk({tag, "_rw"},   32'(cpu_req_rw),    32'(erw));
    if (chg) ls_req_addr = chg_addr;
    for (int i = 1; i < lat; i++) begin
      step;
      chk({tag, "_hold_vld"},  32'(cpu_req_valid), 32'h1);
      chk({tag, "_hold_addr"}, 32'(cpu_req_addr),  32'(ea));
      chk({tag, "_hold_data"}, cpu_req_data,       ed);
      chk({tag, "_hold_rw"},   32'(cpu_req_rw),    32'(erw));
    end
    cpu_res_data  = rd;
    cpu_res_ready = 1'b1;
    step;
    cpu_res_ready = 1'b0;
    if (own_ls) mdl_ls = rd;
    else        mdl_if = rd;
    chk({tag, "_gap_vld"}, 32'(cpu_req_valid), 32'h0);
    chk({tag, "_ifrdy"},   32'(if_res_ready),  32'(!own_ls));
    chk({tag, "_lsrdy"},   32'(ls_res_ready),  32'(own_ls));
    chk({tag, "_ifdat"},   if_res_data,        mdl_if);
    chk({tag, "_lsdat"},   ls_res_data,        mdl_ls);
    step;
    chk({tag, "_idle_vld"}, 32'(cpu_req_valid), 32'h0);
    chk({tag, "_idle_rdy"}, 32'({if_res_ready, ls_res_ready}), 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    if_req_valid = 0; if_req_addr = 0;
    ls_req_valid = 0; ls_req_addr = 0; ls_req_data = 0; ls_req_rw = 0;
    cpu_res_data = 0; cpu_res_ready = 0;
    step; step;
    chk_reset_outs("reset");
    rstn = 1'b1;
    step;

    // Both requesters held valid for four transactions
    if_req_valid = 1; if_req_addr = 27'h111;
    ls_req_valid = 1; ls_req_addr = 27'h222; ls_req_data = 32'h55; ls_req_rw = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    txn("rr0_ls", 27'h222, 32'h55, 1'b0, 1'b1, 2, 32'hA0000001, 1'b0, 27'h0);
    txn("rr1_if", 27'h111, 32'h0,  1'b0, 1'b0, 2, 32'hA0000002, 1'b0, 27'h0);
    txn("rr2_ls", 27'h222, 32'h55, 1'b0, 1'b1, 2, 32'hA0000003, 1'b0, 27'h0);
    txn("rr3_if", 27'h111, 32'h0,  1'b0, 1'b0, 2, 32'hA0000004, 1'b0, 27'h0);
`else
    txn("fp0_ls", 27'h222, 32'h55, 1'b0, 1'b1, 2, 32'hA0000001, 1'b0, 27'h0);
    txn("fp1_ls", 27'h222, 32'h55, 1'b0, 1'b1, 2, 32'hA0000002, 1'b0, 27'h0);
    txn("fp2_ls", 27'h222, 32'h55, 1'b0, 1'b1, 2, 32'hA0000003, 1'b0, 27'h0);
    txn("fp3_ls", 27'h222, 32'h55, 1'b0, 1'b1, 2, 32'hA0000004, 1'b0, 27'h0);
`endif
    if_req_valid = 0; ls_req_valid = 0;

    // Fetch only, 5-cycle cache latency
    if_req_valid = 1; if_req_addr = 27'h100;
    txn("fetch", 27'h100, 32'h0, 1'b0, 1'b0, 5, 32'hDEADBEEF, 1'b0, 27'h0);
    if_req_valid = 0;

    // Store
    ls_req_valid = 1; ls_req_addr = 27'h2000; ls_req_data = 32'h12345678; ls_req_rw = 1;
    txn("store", 27'h2000, 32'h12345678, 1'b1, 1'b1, 3, 32'hCAFE0001, 1'b0, 27'h0);
    ls_req_valid = 0;

    // Request address changes while BUSY
    ls_req_valid = 1; ls_req_addr = 27'h40; ls_req_data = 32'h0; ls_req_rw = 0;
    txn("chg", 27'h40, 32'h0, 1'b0, 1'b1, 4, 32'h0BADF00D, 1'b1, 27'h80);
    ls_req_valid = 0;

    // Spurious cache completion in IDLE
    cpu_res_data = 32'hFFFFFFFF; cpu_res_ready = 1;
    step;
    cpu_res_ready = 0;
    chk("spur_vld", 32'(cpu_req_valid), 32'h0);
    chk("spur_rdy", 32'({if_res_ready, ls_res_ready}), 32'h0);
    step;
    chk("spur_rdy2", 32'({if_res_ready, ls_res_ready}), 32'h0);
    chk("spur_ifdat", if_res_data, mdl_if);
    if_req_valid = 1; if_req_addr = 27'h300;
    txn("post_spur", 27'h300, 32'h0, 1'b0, 1'b0, 2, 32'h30303030, 1'b0, 27'h0);
    if_req_valid = 0;

    // Reset in the middle of BUSY
    if_req_valid = 1; if_req_addr = 27'h400;
    step;
    chk("rstb_vld", 32'(cpu_req_valid), 32'h1);
    step;
    rstn = 0; if_req_valid = 0;
    cpu_res_data = 32'h77777777; cpu_res_ready = 1;
    step;
    mdl_if = 0; mdl_ls = 0;
    chk_reset_outs("rstb");
    rstn = 1; cpu_res_ready = 0;
    step;
    chk("rstb_nopulse", 32'({if_res_ready, ls_res_ready, cpu_req_valid}), 32'h0);
    step;
    chk("rstb_nopulse2", 32'({if_res_ready, ls_res_ready, cpu_req_valid}), 32'h0);
    if_req_valid = 1; if_req_addr = 27'h500;
    txn("post_rst", 27'h500, 32'h0, 1'b0, 1'b0, 4, 32'hA5A5A5A5, 1'b0, 27'h0);
    if_req_valid = 0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
